// File: rtl/pet_stats_engine.sv
// pet_stats_engine: NUM_STATS saturating pet need counters.
//   Stats rise on a periodic game tick (stat picked by random[2:0]), fall on
//   ASCII care commands, and energy drains while the pet sleeps.
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   inputs[7:0]  ASCII command byte, 8'h00 = idle
//   random[7:0]  random source, only [2:0] used
//   second       animation phase, toggles on every tick
//   tick         one-cycle pulse per game tick
//   stats        packed stats, stat i at [i*STAT_W +: STAT_W]
//   is_sleeping  sleep state
//   critical     any stat at STAT_MAX (combinational)
module pet_stats_engine #(
    parameter int unsigned NUM_STATS       = 5,
    parameter int unsigned STAT_W          = 5,
    parameter int unsigned STAT_MAX        = 15,
    parameter int unsigned TICK_CYCLES     = 27000000,
    parameter int unsigned SLEEP_DRAIN_DIV = 2,
    parameter int unsigned ENERGY_IDX      = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    inputs,
    input  logic [7:0]                    random,
    output logic                          second,
    output logic                          tick,
    output logic [NUM_STATS*STAT_W-1:0]   stats,
    output logic                          is_sleeping,
    output logic                          critical
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DRN_W = (SLEEP_DRAIN_DIV > 1) ? $clog2(SLEEP_DRAIN_DIV) : 1;
    localparam int unsigned EXT_W = STAT_W + 1;
    localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(STAT_MAX);

    localparam logic [7:0] CMD_EAT   = 8'h65;
    localparam logic [7:0] CMD_PLAY  = 8'h70;
    localparam logic [7:0] CMD_DOC   = 8'h64;
    localparam logic [7:0] CMD_BATH  = 8'h62;
    localparam logic [7:0] CMD_SLEEP = 8'h73;
    localparam logic [7:0] CMD_WAKE  = 8'h77;

    typedef enum logic {AWAKE = 1'b0, ASLEEP = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic                   tick_q, tick_d;
    logic                   second_q, second_d;
    logic [DRN_W-1:0]       drain_q, drain_d;
    logic                   armed_q, armed_d;
    logic [STAT_W-1:0]      stat_q [NUM_STATS];
    logic [STAT_W-1:0]      stat_d [NUM_STATS];
    logic [EXT_W-1:0]       stat_ext [NUM_STATS];

    logic                   tick_wrap;
    logic                   accept;
    logic                   cmd_care;
    logic                   cmd_sleep;
    logic                   cmd_known;
    logic [2:0]             cmd_idx;
    logic                   drain_fire;
    logic [NUM_STATS-1:0]   inc;
    logic [NUM_STATS-1:0]   dec;

    // Only the low three bits of the random source select a stat.
    logic unused_random;
    assign unused_random = ^random[7:3];

    // Game tick timebase.
    always_comb begin
        tick_wrap  = (tick_cnt_q == CNT_W'(TICK_CYCLES - 1));
        tick_cnt_d = tick_wrap ? '0 : tick_cnt_q + CNT_W'(1);
        tick_d     = tick_wrap;
        second_d   = second_q ^ tick_wrap;
    end

    // Any stat pinned at the ceiling.
    always_comb begin
        critical = 1'b0;
        for (int i = 0; i < int'(NUM_STATS); i++) begin
            if (stat_q[i] == STAT_W'(STAT_MAX)) begin
                critical = 1'b1;
            end
        end
    end

    // Command decode; a care command for a stat that does not exist is unknown.
    always_comb begin
        cmd_care  = 1'b0;
        cmd_sleep = 1'b0;
        cmd_idx   = 3'd0;
        case (inputs)
            CMD_EAT:   begin cmd_care = 1'b1; cmd_idx = 3'd0; end
            CMD_PLAY:  begin cmd_care = 1'b1; cmd_idx = 3'd1; end
            CMD_DOC:   begin cmd_care = 1'b1; cmd_idx = 3'd2; end
            CMD_BATH:  begin cmd_care = 1'b1; cmd_idx = 3'd3; end
            CMD_SLEEP: cmd_sleep = 1'b1;
            default:   ;
        endcase
        cmd_known = cmd_sleep || (cmd_care && ({29'd0, cmd_idx} < NUM_STATS));
        accept    = armed_q && (state_q == AWAKE) && !critical;
    end

    // Edge-detect on the key: re-arm only after an idle byte.
    always_comb begin
        armed_d = armed_q;
        if (inputs == 8'h00) begin
            armed_d = 1'b1;
        end else if (accept && cmd_known) begin
            armed_d = 1'b0;
        end
    end

    // Energy drain divider, counts ticks only while asleep.
    always_comb begin
        drain_d    = drain_q;
        drain_fire = 1'b0;
        if (state_q != ASLEEP) begin
            drain_d = '0;
        end else if (tick_q) begin
            if (drain_q == DRN_W'(SLEEP_DRAIN_DIV - 1)) begin
                drain_d    = '0;
                drain_fire = 1'b1;
            end else begin
                drain_d = drain_q + DRN_W'(1);
            end
        end
    end

    // Per-stat inc/dec and saturating update at one extra bit of headroom.
    always_comb begin
        for (int i = 0; i < int'(NUM_STATS); i++) begin
            inc[i] = tick_q && (random[2:0] == 3'(i));
            dec[i] = (accept && cmd_care && (cmd_idx == 3'(i)))
                   || (drain_fire && (i == int'(ENERGY_IDX)));
            stat_ext[i] = EXT_W'(stat_q[i]) + EXT_W'(inc[i]);
            if (dec[i] && (stat_ext[i] != '0)) begin
                stat_ext[i] = stat_ext[i] - EXT_W'(1);
            end
            if (stat_ext[i] > MAX_EXT) begin
                stat_ext[i] = MAX_EXT;
            end
            stat_d[i] = stat_ext[i][STAT_W-1:0];
        end
    end

    // Sleep FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= AWAKE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sleep FSM: next state. Waking beats everything else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AWAKE:   if (accept && cmd_sleep) state_d = ASLEEP;
            ASLEEP:  if ((inputs == CMD_WAKE) || critical) state_d = AWAKE;
            default: state_d = AWAKE;
        endcase
    end

    // Sleep FSM: outputs.
    always_comb begin
        is_sleeping = (state_q == ASLEEP);
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            second_q   <= 1'b0;
            drain_q    <= '0;
            armed_q    <= 1'b1;
            for (int i = 0; i < int'(NUM_STATS); i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            second_q   <= second_d;
            drain_q    <= drain_d;
            armed_q    <= armed_d;
            for (int i = 0; i < int'(NUM_STATS); i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    always_comb begin
        tick   = tick_q;
        second = second_q;
        for (int i = 0; i < int'(NUM_STATS); i++) begin
            stats[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end

endmodule

// File: tb/tb_pet_stats_engine.sv
// Directed bench for pet_stats_engine with a 4-cycle game tick.
module tb_pet_stats_engine;

    localparam int unsigned NS = 5;
    localparam int unsigned SW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        inputs;
    logic [7:0]        random;
    logic              second;
    logic              tick;
    logic [NS*SW-1:0]  stats;
    logic              is_sleeping;
    logic              critical;

    int checks   = 0;
    int failures = 0;

    pet_stats_engine #(
        .NUM_STATS(NS), .STAT_W(SW), .STAT_MAX(15),
        .TICK_CYCLES(4), .SLEEP_DRAIN_DIV(2), .ENERGY_IDX(4)
    ) dut (
        .clk(clk), .reset(reset), .inputs(inputs), .random(random),
        .second(second), .tick(tick), .stats(stats),
        .is_sleeping(is_sleeping), .critical(critical)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       exp_tick;
        logic       exp_second;
        logic [4:0] exp_stat2;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [4:0] stat(input int i);
        return stats[i*SW +: SW];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inputs = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait for the next tick pulse, then past the edge that applies its update.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        checks++;
        if (!tick) begin
            failures++;
            $display("FAIL tick_timeout: got no tick expected tick within 20 cycles");
        end
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) wait_tick();
    endtask

    task automatic press(input logic [7:0] code);
        inputs = code;
        @(negedge clk);
        inputs = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        vecs = '{
            '{1'b0, 1'b0, 5'd0}, '{1'b0, 1'b0, 5'd0}, '{1'b0, 1'b0, 5'd0},
            '{1'b1, 1'b1, 5'd0}, '{1'b0, 1'b1, 5'd1}, '{1'b0, 1'b1, 5'd1},
            '{1'b0, 1'b1, 5'd1}, '{1'b1, 1'b0, 5'd1}, '{1'b0, 1'b0, 5'd2},
            '{1'b0, 1'b0, 5'd2}, '{1'b0, 1'b0, 5'd2}, '{1'b1, 1'b1, 5'd2},
            '{1'b0, 1'b1, 5'd3}
        };

        random = 8'd7;
        do_reset();
        check("reset_stats", 32'(stats), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_second", 32'(second), 32'd0);
        check("reset_sleep", 32'(is_sleeping), 32'd0);
        check("reset_critical", 32'(critical), 32'd0);

        // Tick cadence and stat 2 increments.
        random = 8'd2;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            check($sformatf("vec%0d_tick", k + 1), 32'(tick), 32'(vecs[k].exp_tick));
            check($sformatf("vec%0d_second", k + 1), 32'(second), 32'(vecs[k].exp_second));
            check($sformatf("vec%0d_stats", k + 1), 32'(stats), 32'(vecs[k].exp_stat2) << 10);
        end

        // Held key acts once.
        do_reset();
        random = 8'd0;
        wait_ticks(3);
        random = 8'd7;
        check("preload_hunger", 32'(stat(0)), 32'd3);
        inputs = 8'h65;
        repeat (20) @(negedge clk);
        inputs = 8'h00;
        @(negedge clk);
        check("held_e", 32'(stat(0)), 32'd2);
        press(8'h65);
        check("second_e", 32'(stat(0)), 32'd1);
        inputs = 8'h77;
        @(negedge clk);
        inputs = 8'h65;
        @(negedge clk);
        inputs = 8'h00;
        @(negedge clk);
        check("w_awake_keeps_armed", 32'(stat(0)), 32'd0);
        check("w_awake_no_sleep", 32'(is_sleeping), 32'd0);
        inputs = 8'h78;
        @(negedge clk);
        inputs = 8'h65;
        @(negedge clk);
        inputs = 8'h00;
        @(negedge clk);
        check("dec_at_zero", 32'(stat(0)), 32'd0);

        // Sleep and energy drain.
        do_reset();
        random = 8'd0;
        wait_tick();
        random = 8'd4;
        wait_ticks(5);
        random = 8'd7;
        check("preload_energy", 32'(stat(4)), 32'd5);
        press(8'h73);
        check("sleep_entered", 32'(is_sleeping), 32'd1);
        wait_ticks(2);
        check("drain_2ticks", 32'(stat(4)), 32'd4);
        wait_ticks(2);
        check("drain_4ticks", 32'(stat(4)), 32'd3);
        press(8'h65);
        check("e_while_asleep", 32'(stat(0)), 32'd1);
        inputs = 8'h77;
        @(negedge clk);
        inputs = 8'h00;
        check("wake_w", 32'(is_sleeping), 32'd0);

        // Saturation and critical.
        do_reset();
        random = 8'd1;
        wait_ticks(2);
        random = 8'd0;
        wait_ticks(14);
        check("climb_14", 32'(stat(0)), 32'd14);
        check("not_critical_14", 32'(critical), 32'd0);
        press(8'h73);
        check("sleep_before_crit", 32'(is_sleeping), 32'd1);
        wait_tick();
        check("climb_15", 32'(stat(0)), 32'd15);
        check("critical_set", 32'(critical), 32'd1);
        @(negedge clk);
        check("critical_wakes", 32'(is_sleeping), 32'd0);
        random = 8'd7;
        press(8'h70);
        check("p_blocked", 32'(stat(1)), 32'd2);
        press(8'h73);
        check("s_blocked", 32'(is_sleeping), 32'd0);
        random = 8'd0;
        wait_ticks(3);
        check("saturated", 32'(stat(0)), 32'd15);
        check("critical_held", 32'(critical), 32'd1);

        // Drain and increment collide on energy.
        do_reset();
        random = 8'd4;
        wait_ticks(7);
        random = 8'd7;
        press(8'h73);
        check("collide_sleep", 32'(is_sleeping), 32'd1);
        wait_tick();
        random = 8'd4;
        wait_tick();
        random = 8'd7;
        check("collision_net_zero", 32'(stat(4)), 32'd7);
        wait_ticks(2);
        check("drain_after_collision", 32'(stat(4)), 32'd6);

        // Async reset with no clock edge.
        #1 reset = 1'b1;
        #1;
        check("async_stats", 32'(stats), 32'd0);
        check("async_sleep", 32'(is_sleeping), 32'd0);
        check("async_second_tick", {30'd0, second, tick}, 32'd0);
        check("async_critical", 32'(critical), 32'd0);
        #1 reset = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tick && n < 20);
            check("tick_restart", 32'(n), 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
